// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream and instruction-memory write bus of the program loader.
//   rx_rdata/rx_rdata_ready/rx_ferr : received UART byte, its strobe and framing-error flag
//   tx_busy/tx_sdata/tx_start       : UART transmitter handshake
//   imem_we/imem_addr/imem_wdata    : one-cycle word write into instruction memory
//   master = loader side, slave = UART/memory side
interface program_loader_if #(
    parameter int IMEM_ADDR_WIDTH = 14
);
    logic [7:0]                 rx_rdata;
    logic                       rx_rdata_ready;
    logic                       rx_ferr;
    logic                       tx_busy;
    logic [7:0]                 tx_sdata;
    logic                       tx_start;
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_wdata;
    modport master (
        input  rx_rdata, rx_rdata_ready, rx_ferr, tx_busy,
        output tx_sdata, tx_start, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        output rx_rdata, rx_rdata_ready, rx_ferr, tx_busy,
        input  tx_sdata, tx_start, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: UART boot loader; sends 0x99, receives a 32-bit size and the program bytes,
// writes little-endian words to instruction memory, answers 0xAA and releases the core.
//   clk, reset   : single clock, synchronous active-high reset
//   bus (master) : UART rx/tx handshake and instruction-memory write port
//   program_size : received program size in bytes
//   load_done    : level, load complete
//   cpu_start    : one-cycle pulse releasing the core
//   error        : sticky load failure
module program_loader #(
    parameter int IMEM_ADDR_WIDTH   = 14,
    parameter int MAX_PROGRAM_BYTES = 65536
) (
    input  logic                    clk,
    input  logic                    reset,
    program_loader_if.master        bus,
    output logic [31:0]             program_size,
    output logic                    load_done,
    output logic                    cpu_start,
    output logic                    error
);
    typedef enum logic [2:0] {SEND_99, RECV_SIZE, RECV_PROG, SEND_AA, DONE, ERROR} state_t;
    state_t                     state_q, state_d;
    logic [31:0]                cnt_q, cnt_d, size_q, size_d, wdata_q, wdata_d, size_full;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                 sdata_q, sdata_d;
    logic                       start_q, start_d, guard_q, we_q, we_d;
    logic                       done_q, done_d, cpu_q, cpu_d, err_q, err_d;
    logic                       tx_ok, rx_ok, rx_bad;
    // The transmitter raises tx_busy only after it has seen tx_start, so the pulse cycle and the
    // cycle after it must not trust a low tx_busy.
    assign tx_ok     = !bus.tx_busy && !start_q && !guard_q;
    assign rx_ok     = bus.rx_rdata_ready && !bus.rx_ferr;
    assign rx_bad    = bus.rx_rdata_ready && bus.rx_ferr;
    assign size_full = {bus.rx_rdata, size_q[23:0]};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        start_d = 1'b0;
        we_d    = 1'b0;
        done_d  = done_q;
        cpu_d   = 1'b0;
        case (state_q)
            SEND_99: if (tx_ok) begin
                start_d = 1'b1;
                sdata_d = 8'h99;
                state_d = RECV_SIZE;
            end
            RECV_SIZE: if (rx_bad) state_d = ERROR;
            else if (rx_ok) begin
                size_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_rdata;
                cnt_d = cnt_q + 32'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = size_full == '0 ? SEND_AA :
                              (size_full > 32'(MAX_PROGRAM_BYTES) || size_full[1:0] != 2'd0) ? ERROR :
                              RECV_PROG;
                end
            end
            RECV_PROG: if (rx_bad) state_d = ERROR;
            else if (rx_ok) begin
                wdata_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_rdata;
                cnt_d = cnt_q + 32'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[IMEM_ADDR_WIDTH+1:2];
                end
                // size is a multiple of 4, so the last byte always completes a word
                if (cnt_q + 32'd1 == size_q) state_d = SEND_AA;
            end
            SEND_AA: if (tx_ok) begin
                start_d = 1'b1;
                sdata_d = 8'hAA;
                state_d = DONE;
                done_d  = 1'b1;
                cpu_d   = 1'b1;
            end
            default: ;
        endcase
        err_d = err_q || state_d == ERROR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEND_99;
            cnt_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            start_q <= 1'b0;
            guard_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            cpu_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            start_q <= start_d;
            guard_q <= start_q;
            we_q    <= we_d;
            done_q  <= done_d;
            cpu_q   <= cpu_d;
            err_q   <= err_d;
        end
    end
    assign bus.tx_sdata   = sdata_q;
    assign bus.tx_start   = start_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign program_size   = size_q;
    assign load_done      = done_q;
    assign cpu_start      = cpu_q;
    assign error          = err_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader against a load-level reference model.
module tb_program_loader;
    localparam int AW   = 14;
    localparam int MAXB = 64;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] program_size;
    logic        load_done, cpu_start, error;
    program_loader_if #(.IMEM_ADDR_WIDTH(AW)) bus ();
    program_loader #(.IMEM_ADDR_WIDTH(AW), .MAX_PROGRAM_BYTES(MAXB)) dut (
        .clk(clk), .reset(reset), .bus(bus), .program_size(program_size),
        .load_done(load_done), .cpu_start(cpu_start), .error(error)
    );
    always #5 clk = ~clk;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_tx_cyc = 0;
    int          cpu_cnt = 0;
    int          busy_cnt = 0;
    logic        hold_busy = 1'b0;
    logic        busy_at_edge = 1'b0;
    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    logic [7:0]  prog_q[$];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // transmitter model: busy for a few cycles after every request, or forced busy by the stimulus
    assign bus.tx_busy = hold_busy || busy_cnt != 0;
    always @(posedge clk) begin
        cyc++;
        busy_at_edge <= bus.tx_busy;
    end
    always @(negedge clk) begin
        if (bus.tx_start) begin
            check("tx_start_while_busy", 64'(busy_at_edge), 64'd0);
            tx_q.push_back(bus.tx_sdata);
            last_tx_cyc = cyc;
            busy_cnt = int'($urandom_range(2, 8));
        end else if (busy_cnt > 0) busy_cnt--;
        if (bus.imem_we) wr_q.push_back({32'(bus.imem_addr), bus.imem_wdata});
        if (cpu_start) cpu_cnt++;
    end
    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_rdata = 8'h00;
        bus.rx_rdata_ready = 1'b0;
        bus.rx_ferr = 1'b0;
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", 64'({bus.tx_sdata, bus.tx_start}), 64'd0);
        check("rst_imem", 64'({bus.imem_we, bus.imem_addr, bus.imem_wdata}), 64'd0);
        check("rst_status", 64'({program_size, load_done, cpu_start, error}), 64'd0);
        tx_q.delete();
        wr_q.delete();
        cpu_cnt = 0;
        reset = 1'b0;
    endtask
    task automatic wait_99();
        for (int i = 0; i < 100 && tx_q.size() == 0; i++) @(negedge clk);
        check("tx_99_seen", 64'(tx_q.size()), 64'd1);
    endtask
    task automatic send_byte(input logic [7:0] b, input logic ferr);
        @(negedge clk);
        bus.rx_rdata = b;
        bus.rx_ferr = ferr;
        bus.rx_rdata_ready = 1'b1;
        @(negedge clk);
        bus.rx_rdata_ready = 1'b0;
        bus.rx_ferr = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask
    task automatic fill(input int n);
        prog_q.delete();
        repeat (n) prog_q.push_back(8'($urandom));
    endtask
    // ferr_at indexes the whole stream: 0..3 size bytes, 4.. program bytes, -1 none
    task automatic run_load(input int size, input int ferr_at, input bit hold_aa, input int trailing);
        logic [7:0]  s[$];
        logic [31:0] sz;
        bit          err;
        int          nw;
        int          rel;
        sz = 32'(size);
        s = {sz[7:0], sz[15:8], sz[23:16], sz[31:24]};
        foreach (prog_q[i]) s.push_back(prog_q[i]);
        reset_dut();
        wait_99();
        foreach (s[i]) begin
            if (hold_aa && i == s.size() - 1) hold_busy = 1'b1;
            send_byte(s[i], i == ferr_at);
        end
        if (hold_aa) begin
            repeat (50) @(negedge clk);
            hold_busy = 1'b0;
            rel = cyc;
            for (int i = 0; i < 50 && tx_q.size() < 2; i++) @(negedge clk);
            check("aa_after_busy_falls", 64'(last_tx_cyc - rel), 64'd1);
        end
        repeat (trailing) send_byte(8'($urandom), 1'b0);
        for (int i = 0; i < 400 && !(load_done || error); i++) @(negedge clk);
        repeat (10) @(negedge clk);
        err = 1'b0;
        nw = 0;
        if (ferr_at >= 0 && ferr_at < 4) err = 1'b1;
        else if (size == 0) nw = 0;
        else if (size > MAXB || size % 4 != 0) err = 1'b1;
        else begin
            nw = size / 4;
            if (ferr_at >= 4 && ferr_at - 4 < size) begin
                err = 1'b1;
                nw = (ferr_at - 4) / 4;
            end
        end
        check("tx_count", 64'(tx_q.size()), err ? 64'd1 : 64'd2);
        check("tx_first", 64'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 64'h99);
        check("tx_second", 64'(tx_q.size() > 1 ? tx_q[1] : 8'h00), err ? 64'h00 : 64'hAA);
        check("wr_count", 64'(wr_q.size()), 64'(nw));
        for (int k = 0; k < nw && k < wr_q.size(); k++)
            check("wr_word", wr_q[k], {32'(k), s[4*k+7], s[4*k+6], s[4*k+5], s[4*k+4]});
        check("cpu_start_count", 64'(cpu_cnt), err ? 64'd0 : 64'd1);
        check("load_done", 64'(load_done), 64'(!err));
        check("error", 64'(error), 64'(err));
        if (!(ferr_at >= 0 && ferr_at < 4)) check("program_size", 64'(program_size), 64'(sz));
    endtask
    initial begin
        bus.rx_rdata = 8'h00;
        bus.rx_rdata_ready = 1'b0;
        bus.rx_ferr = 1'b0;
        prog_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(8, -1, 1'b0, 2);
        fill(0);
        run_load(0, -1, 1'b0, 1);
        fill(6);
        run_load(6, -1, 1'b0, 0);
        fill(8);
        run_load(8, 5, 1'b0, 0);
        fill(8);
        run_load(16, 2, 1'b0, 0);
        fill(8);
        run_load(MAXB + 4, -1, 1'b0, 0);
        fill(MAXB);
        run_load(MAXB, -1, 1'b0, 0);
        fill(8);
        run_load(8, -1, 1'b1, 0);
        reset_dut();
        wait_99();
        foreach (prog_q[i]) if (i < 5) begin
            if (i == 0) begin
                send_byte(8'h08, 1'b0);
                repeat (3) send_byte(8'h00, 1'b0);
            end
            send_byte(prog_q[i], 1'b0);
        end
        repeat (3) @(negedge clk);
        check("partial_wr_count", 64'(wr_q.size()), 64'd1);
        fill(8);
        run_load(8, -1, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            int size;
            int ferr_at;
            size = 4 * int'($urandom_range(0, MAXB / 4));
            fill(size);
            ferr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, size + 3)) : -1;
            run_load(size, ferr_at, 1'b0, int'($urandom_range(0, 3)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IMEM_ADDR_WIDTH, default 14, the word-address width of the instruction memory.
REQ-002 SHALL have parameter MAX_PROGRAM_BYTES, default 65536, the largest accepted program size in bytes.
REQ-003 clk  input  1  single clock, all logic on posedge; one clock; reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 rx_rdata  input  8  byte from the UART receiver.
REQ-006 rx_rdata_ready  input  1  one-cycle strobe, rx_rdata valid.
REQ-007 rx_ferr  input  1  framing error flag, sampled with rx_rdata_ready.
REQ-008 tx_busy  input  1  UART transmitter busy.
REQ-009 tx_sdata  output  8  byte to transmit.
REQ-010 tx_start  output  1  one-cycle transmit request.
REQ-011 imem_we  output  1  one-cycle instruction-memory write enable.
REQ-012 imem_addr  output  IMEM_ADDR_WIDTH  word address of the write.
REQ-013 imem_wdata  output  32  write data.
REQ-014 program_size  output  32  received program size in bytes.
REQ-015 load_done  output  1  level, load complete.
REQ-016 cpu_start  output  1  one-cycle pulse releasing the core.
REQ-017 error  output  1  sticky load failure.

Function
REQ-018 States SHALL be SEND_99, RECV_SIZE, RECV_PROG, SEND_AA, DONE, ERROR.
REQ-019 SEND_99: when tx_busy=0 and no guard is pending, SHALL drive tx_sdata=0x99 and pulse tx_start for one cycle, then enter RECV_SIZE.
REQ-020 After any tx_start pulse, SHALL ignore tx_busy for one cycle (guard) before issuing another request.
REQ-021 RECV_SIZE: SHALL take 4 bytes on rx_rdata_ready, LSB first, into program_size.
REQ-022 After the 4th size byte: size=0 goes to SEND_AA; size>MAX_PROGRAM_BYTES or size[1:0]!=0 goes to ERROR; otherwise goes to RECV_PROG.
REQ-023 RECV_PROG: byte n (from 0) SHALL land in imem_wdata bits [8*(n%4)+7 : 8*(n%4)] (little-endian).
REQ-024 On each 4th byte, imem_we SHALL pulse in the next cycle with imem_addr=n/4 and the assembled word (1-cycle latency).
REQ-025 After the write of the final word (byte count = program_size), SHALL enter SEND_AA.
REQ-026 SEND_AA: SHALL send 0xAA under the same handshake as SEND_99, deferred while tx_busy=1, then enter DONE.
REQ-027 On entry to DONE, SHALL assert load_done and hold it, and pulse cpu_start exactly once.
REQ-028 rx_rdata_ready with rx_ferr=1 in RECV_SIZE or RECV_PROG SHALL enter ERROR and discard the byte.
REQ-029 ERROR: SHALL hold error=1; no further tx_start, imem_we or cpu_start until reset.
REQ-030 rx bytes arriving in SEND_99, SEND_AA, DONE or ERROR SHALL be ignored.
REQ-031 The byte counter SHALL be 32 bits wide and SHALL not wrap within MAX_PROGRAM_BYTES.

Reset
REQ-032 With reset=1 at a posedge: state=SEND_99, counters=0, program_size=0, tx_sdata=0x00, and tx_start, imem_we, imem_addr, imem_wdata, load_done, cpu_start, error all 0.
REQ-033 Reset mid-load SHALL abandon the partial word, and SHALL re-send 0x99 after release.

Verification
REQ-034 Reset release with tx_busy=0: exactly one tx_start pulse with tx_sdata=0x99; none after.
REQ-035 Size 08 00 00 00, then bytes 13 00 00 00 93 00 10 00: imem writes addr0=0x00000013 and addr1=0x00100093; then 0xAA sent; cpu_start pulses once; load_done=1; program_size=8.
REQ-036 Size 00 00 00 00: no imem_we; 0xAA sent; DONE reached.
REQ-037 Size 06 00 00 00, or rx_ferr=1 on the 2nd program byte: error=1; no 0xAA; no further writes.
REQ-038 tx_busy held high for 50 cycles when 0xAA is due: tx_start stays 0 until the cycle after tx_busy falls.
REQ-039 Reset after 5 program bytes, then a full 8-byte load: outputs zero during reset; 0x99 re-sent; writes start at addr0 with correct data.
